// File: rtl/proc_control.sv
// proc_control: multi-cycle control sequencer for a 16-bit, 8-register datapath.
// When run is sampled high in IDLE, the instruction is latched into IR. The
// sequencer then steps through T1..T3 and drives the operand multiplexer and
// the load controls for the register file, A, G and the ALU.
//
// Ports:
//   clock, reset    rising-edge clock; synchronous active-high reset
//   run             start request, sampled only in IDLE
//   instr           instruction word {opcode[15:12], rx[11:9], ry[8:6], imm[5:0]}
//   regNumSelect    register index driven onto the bus multiplexer
//   Rselect         multiplexer selects G (ALU result)
//   Iselect         multiplexer selects signExt
//   signExt         IR immediate field, sign-extended to DATA_WIDTH
//   reg_load        one-hot write enable for r0..r7
//   a_load, g_load  load operand register A / result register G
//   alu_sub         1 = A - bus, 0 = A + bus
//   done, illegal   pulse in the last T-state; illegal marks an undefined opcode
//   busy            high whenever the sequencer is not in IDLE
//   instr_count     completed-instruction counter (wraps)
module proc_control #(
  parameter int DATA_WIDTH = 16,
  parameter int IMM_WIDTH  = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  input  logic [15:0]           instr,
  output logic [2:0]            regNumSelect,
  output logic                  Rselect,
  output logic                  Iselect,
  output logic [DATA_WIDTH-1:0] signExt,
  output logic [7:0]            reg_load,
  output logic                  a_load,
  output logic                  g_load,
  output logic                  alu_sub,
  output logic                  done,
  output logic                  illegal,
  output logic                  busy,
  output logic [15:0]           instr_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    T1   = 2'd1,
    T2   = 2'd2,
    T3   = 2'd3
  } state_t;

  localparam logic [3:0] OP_MV   = 4'b0000;
  localparam logic [3:0] OP_MVI  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   ir_reg;
  logic [15:0]             count_reg;

  logic [3:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       rx_we;   // write the bus value into register rx this cycle

  assign opcode = ir_reg[15:12];
  assign rx     = ir_reg[11:9];
  assign ry     = ir_reg[8:6];

  // State, instruction register and completion counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      ir_reg    <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && run) begin
        ir_reg <= instr;
      end
      if (done) begin
        count_reg <= count_reg + 16'd1;
      end
    end
  end

  // Next-state and control decode; everything is idle unless a state asserts it.
  always_comb begin
    state_next   = state_reg;
    regNumSelect = 3'd0;
    Rselect      = 1'b0;
    Iselect      = 1'b0;
    rx_we        = 1'b0;
    a_load       = 1'b0;
    g_load       = 1'b0;
    alu_sub      = 1'b0;
    done         = 1'b0;
    illegal      = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (run) begin
          state_next = T1;
        end
      end

      T1: begin
        unique case (opcode)
          OP_MV: begin
            regNumSelect = ry;
            rx_we        = 1'b1;
            done         = 1'b1;
            state_next   = IDLE;
          end
          OP_MVI: begin
            Iselect    = 1'b1;
            rx_we      = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
          end
          OP_ADD, OP_SUB, OP_ADDI: begin
            // A captures the old rx, so rx == ry yields 2*rx.
            regNumSelect = rx;
            a_load       = 1'b1;
            state_next   = T2;
          end
          default: begin
            done       = 1'b1;
            illegal    = 1'b1;
            state_next = IDLE;
          end
        endcase
      end

      T2: begin
        g_load     = 1'b1;
        state_next = T3;
        if (opcode == OP_ADDI) begin
          Iselect = 1'b1;
        end else begin
          regNumSelect = ry;
          alu_sub      = (opcode == OP_SUB);
        end
      end

      T3: begin
        Rselect    = 1'b1;
        rx_we      = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One-hot decode of rx into the register-file write enables.
  for (genvar gi = 0; gi < 8; gi++) begin : g_reg_load
    assign reg_load[gi] = rx_we && (rx == 3'(gi));
  end

  assign signExt     = {{(DATA_WIDTH-IMM_WIDTH){ir_reg[IMM_WIDTH-1]}}, ir_reg[IMM_WIDTH-1:0]};
  assign busy        = (state_reg != IDLE);
  assign instr_count = count_reg;

endmodule

// File: tb/tb_proc_control.sv
// Directed testbench for proc_control with hand-computed expected values.
module tb_proc_control;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] instr;
  logic [2:0]  regNumSelect;
  logic        Rselect;
  logic        Iselect;
  logic [15:0] signExt;
  logic [7:0]  reg_load;
  logic        a_load;
  logic        g_load;
  logic        alu_sub;
  logic        done;
  logic        illegal;
  logic        busy;
  logic [15:0] instr_count;

  int checks   = 0;
  int failures = 0;

  proc_control dut (
    .clock        (clock),
    .reset        (reset),
    .run          (run),
    .instr        (instr),
    .regNumSelect (regNumSelect),
    .Rselect      (Rselect),
    .Iselect      (Iselect),
    .signExt      (signExt),
    .reg_load     (reg_load),
    .a_load       (a_load),
    .g_load       (g_load),
    .alu_sub      (alu_sub),
    .done         (done),
    .illegal      (illegal),
    .busy         (busy),
    .instr_count  (instr_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    instr = 16'h0000;

    // Reset held two cycles, run low.
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_reg_load", 32'(reg_load), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    check("rst_regnum", 32'(regNumSelect), 32'd0);
    check("rst_rsel", 32'(Rselect), 32'd0);
    check("rst_isel", 32'(Iselect), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // MVI r2,-3
    instr = 16'h147D;
    run   = 1'b1;
    tick();
    run = 1'b0;
    check("mvi_t1_busy", 32'(busy), 32'd1);
    check("mvi_t1_isel", 32'(Iselect), 32'd1);
    check("mvi_t1_rsel", 32'(Rselect), 32'd0);
    check("mvi_t1_signext", 32'(signExt), 32'hFFFD);
    check("mvi_t1_reg_load", 32'(reg_load), 32'h04);
    check("mvi_t1_done", 32'(done), 32'd1);
    check("mvi_t1_illegal", 32'(illegal), 32'd0);
    tick();
    check("mvi_idle_busy", 32'(busy), 32'd0);
    check("mvi_idle_done", 32'(done), 32'd0);
    check("mvi_count", 32'(instr_count), 32'd1);

    // ADD r1,r5
    instr = 16'h2340;
    run   = 1'b1;
    tick();
    run = 1'b0;
    check("add_t1_regnum", 32'(regNumSelect), 32'd1);
    check("add_t1_a_load", 32'(a_load), 32'd1);
    check("add_t1_reg_load", 32'(reg_load), 32'd0);
    check("add_t1_done", 32'(done), 32'd0);
    tick();
    check("add_t2_regnum", 32'(regNumSelect), 32'd5);
    check("add_t2_g_load", 32'(g_load), 32'd1);
    check("add_t2_alu_sub", 32'(alu_sub), 32'd0);
    check("add_t2_isel", 32'(Iselect), 32'd0);
    tick();
    check("add_t3_rsel", 32'(Rselect), 32'd1);
    check("add_t3_reg_load", 32'(reg_load), 32'h02);
    check("add_t3_done", 32'(done), 32'd1);
    tick();
    check("add_idle_busy", 32'(busy), 32'd0);
    check("add_count", 32'(instr_count), 32'd2);

    // Reset beats run in the same cycle.
    reset = 1'b1;
    run   = 1'b1;
    instr = 16'h147D;
    tick();
    reset = 1'b0;
    run   = 1'b0;
    check("rstpri_busy", 32'(busy), 32'd0);
    check("rstpri_count", 32'(instr_count), 32'd0);

    // SUB r4,r6 with run held and instr switched to MV r3,r2 mid-flight.
    instr = 16'h3980;
    run   = 1'b1;
    tick();
    instr = 16'h0680;
    check("sub_t1_regnum", 32'(regNumSelect), 32'd4);
    check("sub_t1_a_load", 32'(a_load), 32'd1);
    tick();
    check("sub_t2_regnum", 32'(regNumSelect), 32'd6);
    check("sub_t2_alu_sub", 32'(alu_sub), 32'd1);
    check("sub_t2_g_load", 32'(g_load), 32'd1);
    tick();
    check("sub_t3_reg_load", 32'(reg_load), 32'h10);
    check("sub_t3_done", 32'(done), 32'd1);
    check("sub_t3_rsel", 32'(Rselect), 32'd1);
    tick();
    check("b2b_idle_busy", 32'(busy), 32'd0);
    check("b2b_idle_done", 32'(done), 32'd0);
    check("b2b_idle_count", 32'(instr_count), 32'd1);
    tick();
    run = 1'b0;
    check("mv_t1_regnum", 32'(regNumSelect), 32'd2);
    check("mv_t1_reg_load", 32'(reg_load), 32'h08);
    check("mv_t1_done", 32'(done), 32'd1);
    check("mv_t1_isel", 32'(Iselect), 32'd0);
    tick();
    check("mv_count", 32'(instr_count), 32'd2);

    // Illegal opcode.
    instr = 16'hF000;
    run   = 1'b1;
    tick();
    run = 1'b0;
    check("ill_t1_done", 32'(done), 32'd1);
    check("ill_t1_illegal", 32'(illegal), 32'd1);
    check("ill_t1_reg_load", 32'(reg_load), 32'd0);
    check("ill_t1_a_load", 32'(a_load), 32'd0);
    tick();
    check("ill_idle_illegal", 32'(illegal), 32'd0);
    check("ill_count", 32'(instr_count), 32'd3);

    // ADDI r7,+31 aborted by reset in T2.
    instr = 16'h4E1F;
    run   = 1'b1;
    tick();
    run = 1'b0;
    check("addi_t1_regnum", 32'(regNumSelect), 32'd7);
    check("addi_t1_a_load", 32'(a_load), 32'd1);
    tick();
    check("addi_t2_isel", 32'(Iselect), 32'd1);
    check("addi_t2_g_load", 32'(g_load), 32'd1);
    check("addi_t2_signext", 32'(signExt), 32'h001F);
    check("addi_t2_alu_sub", 32'(alu_sub), 32'd0);
    reset = 1'b1;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_reg_load", 32'(reg_load), 32'd0);
    check("abort_count", 32'(instr_count), 32'd0);
    reset = 1'b0;
    tick();
    check("post_abort_busy", 32'(busy), 32'd0);
    check("post_abort_done", 32'(done), 32'd0);
    check("post_abort_reg_load", 32'(reg_load), 32'd0);
    check("post_abort_count", 32'(instr_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
